// File: rtl/icache_line_refill.sv
// I-cache refill engine: one 4-beat read burst per miss, assembled into a line and written to the data RAM in one cycle.
// Optional critical-word-first wrap burst and early word forwarding when ICACHE_REFILL_CWF_EN is defined.
module icache_line_refill #(
   parameter int INDEX_WIDTH    = 7,
   parameter int WORD_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic [31:0]                           req_paddr,
   output logic                                  ar_valid,
   input  logic                                  ar_ready,
   output logic [31:0]                           ar_addr,
   output logic [3:0]                            ar_len,
   output logic [1:0]                            ar_burst,
   input  logic                                  r_valid,
   output logic                                  r_ready,
   input  logic [WORD_WIDTH-1:0]                 r_data,
   input  logic                                  r_last,
   output logic [INDEX_WIDTH-1:0]                ram_addr,
   output logic [WORD_WIDTH*WORDS_PER_LINE/8-1:0] ram_strobe,
   output logic [WORD_WIDTH*WORDS_PER_LINE-1:0]  ram_wdata,
   output logic                                  done,
   output logic                                  err
`ifdef ICACHE_REFILL_CWF_EN
   ,
   output logic                                  crit_valid,
   output logic [WORD_WIDTH-1:0]                 crit_data
`endif
);

   localparam int PTR_W = $clog2(WORDS_PER_LINE);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      DATA  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t                                    state_q;
   state_t                                    state_d;
   logic [31:0]                               paddr_q;
   logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] line_q;
   logic [PTR_W-1:0]                          w_q;
   logic [CNT_W-1:0]                          cnt_q;
   logic                                      err_q;

   logic                                      beat;
   logic                                      final_beat;
   logic                                      beat_last;
   logic                                      beat_err;
   logic [PTR_W-1:0]                          w_init;

   assign beat       = (state_q == DATA) && r_valid;
   assign final_beat = (cnt_q == CNT_W'(WORDS_PER_LINE - 1));
   // A beat ends the burst either on r_last or as the 4th beat; any disagreement between the two is an error.
   assign beat_last  = r_last || final_beat;
   assign beat_err   = (r_last != final_beat);

   assign ar_len = 4'(WORDS_PER_LINE - 1);
   assign err    = err_q;

`ifdef ICACHE_REFILL_CWF_EN
   logic unused_addr_bits;
   assign unused_addr_bits = ^paddr_q[1:0];
   assign w_init   = req_paddr[PTR_W+1:2];
   assign ar_addr  = {paddr_q[31:2], 2'b00};
   assign ar_burst = 2'b10;
   assign crit_valid = beat && (cnt_q == '0);
   assign crit_data  = crit_valid ? r_data : '0;
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^paddr_q[3:0];
   assign w_init   = '0;
   assign ar_addr  = {paddr_q[31:4], 4'b0000};
   assign ar_burst = 2'b01;
`endif

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      ar_valid   = 1'b0;
      r_ready    = 1'b0;
      done       = 1'b0;
      ram_addr   = '0;
      ram_strobe = '0;
      ram_wdata  = '0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = ADDR;
            end
         end
         ADDR: begin
            ar_valid = 1'b1;
            if (ar_ready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            r_ready = 1'b1;
            if (r_valid && beat_last) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            done       = 1'b1;
            ram_addr   = paddr_q[INDEX_WIDTH+3:4];
            ram_strobe = '1;
            ram_wdata  = line_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         paddr_q <= '0;
         line_q  <= '0;
         w_q     <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && req_valid) begin
            paddr_q <= req_paddr;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            w_q     <= w_init;
         end
         // Words not delivered by a short burst keep whatever the buffer held before.
         if (beat) begin
            line_q[w_q] <= r_data;
            w_q         <= w_q + PTR_W'(1);
            cnt_q       <= cnt_q + CNT_W'(1);
            if (beat_err) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   ar_addr_stable: assert property (@(posedge clk) disable iff (reset)
      (ar_valid && !ar_ready) |=> (ar_valid && $stable(ar_addr)));

   strobe_only_on_done: assert property (@(posedge clk) disable iff (reset)
      ((|ram_strobe) == done));

   ready_only_idle: assert property (@(posedge clk) disable iff (reset)
      !(req_ready && (ar_valid || r_ready || done)));

endmodule

// File: tb/tb_icache_line_refill.sv
// Directed bench for icache_line_refill: reset, latency, stalls, burst-length errors, back-to-back requests, optional CWF.
module tb_icache_line_refill;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic [31:0]  req_paddr;
   logic         ar_valid;
   logic         ar_ready;
   logic [31:0]  ar_addr;
   logic [3:0]   ar_len;
   logic [1:0]   ar_burst;
   logic         r_valid;
   logic         r_ready;
   logic [31:0]  r_data;
   logic         r_last;
   logic [6:0]   ram_addr;
   logic [15:0]  ram_strobe;
   logic [127:0] ram_wdata;
   logic         done;
   logic         err;
`ifdef ICACHE_REFILL_CWF_EN
   logic         crit_valid;
   logic [31:0]  crit_data;
   localparam logic [31:0]  BASIC_AR_ADDR  = 32'h1FC0_0124;
   localparam logic [1:0]   BASIC_AR_BURST = 2'b10;
   localparam logic [127:0] BASIC_LINE     = 128'h00000033_00000022_00000011_00000044;
`else
   localparam logic [31:0]  BASIC_AR_ADDR  = 32'h1FC0_0120;
   localparam logic [1:0]   BASIC_AR_BURST = 2'b01;
   localparam logic [127:0] BASIC_LINE     = 128'h00000044_00000033_00000022_00000011;
`endif

   int passed = 0;
   int total  = 0;
   int done_cnt = 0;
   int strobe_cnt = 0;

   icache_line_refill #(.INDEX_WIDTH(7), .WORD_WIDTH(32), .WORDS_PER_LINE(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_paddr(req_paddr),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len), .ar_burst(ar_burst),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
      .ram_addr(ram_addr), .ram_strobe(ram_strobe), .ram_wdata(ram_wdata),
      .done(done), .err(err)
`ifdef ICACHE_REFILL_CWF_EN
      , .crit_valid(crit_valid), .crit_data(crit_data)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (|ram_strobe) strobe_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
      $fatal(1, "watchdog");
   end

   // Issues one request from IDLE and serves nbeats beats; returns the cycle done was seen (-1 on timeout).
   task automatic run_line(input logic [31:0] addr, input logic [127:0] beats, input int nbeats,
                           input int last_at, output int cyc, output logic [127:0] wd,
                           output logic [6:0] ra, output logic er);
      int bi = 0;
      cyc = -1; wd = '0; ra = '0; er = 1'b0;
      req_valid = 1'b1; req_paddr = addr; ar_ready = 1'b1; r_valid = 1'b0; r_last = 1'b0;
      for (int t = 1; t <= 40 && cyc < 0; t++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (done) begin
            cyc = t; wd = ram_wdata; ra = ram_addr; er = err;
            r_valid = 1'b0; r_last = 1'b0;
         end else if (r_ready && bi < nbeats) begin
            r_valid = 1'b1; r_data = beats[32*bi +: 32]; r_last = (bi + 1 == last_at); bi++;
         end else begin
            r_valid = 1'b0; r_last = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b0; req_paddr = '0; ar_ready = 1'b0;
      r_valid = 1'b0; r_data = '0; r_last = 1'b0;
      @(negedge clk);
      total++; if (ar_valid !== 1'b0) $display("FAIL reset ar_valid got %b exp 0", ar_valid); else passed++;
      total++; if (r_ready !== 1'b0) $display("FAIL reset r_ready got %b exp 0", r_ready); else passed++;
      total++; if (ram_strobe !== 16'h0) $display("FAIL reset ram_strobe got %h exp 0", ram_strobe); else passed++;
      total++; if (ram_wdata !== 128'h0) $display("FAIL reset ram_wdata got %h exp 0", ram_wdata); else passed++;
      total++; if ({done, err} !== 2'b00) $display("FAIL reset done_err got %b exp 00", {done, err}); else passed++;
      reset = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) $display("FAIL reset req_ready got %b exp 1", req_ready); else passed++;
   endtask

   task automatic test_basic_latency;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         case (c)
            0: begin
               total++; if (req_ready !== 1'b1) $display("FAIL basic c0 req_ready got %b exp 1", req_ready); else passed++;
               req_valid = 1'b1; req_paddr = 32'h1FC0_0124; ar_ready = 1'b1; r_valid = 1'b1; r_data = '0;
            end
            1: begin
               req_valid = 1'b0;
               total++; if (ar_valid !== 1'b1) $display("FAIL basic ar_valid got %b exp 1", ar_valid); else passed++;
               total++; if (ar_addr !== BASIC_AR_ADDR) $display("FAIL basic ar_addr got %h exp %h", ar_addr, BASIC_AR_ADDR); else passed++;
               total++; if (ar_len !== 4'd3) $display("FAIL basic ar_len got %0d exp 3", ar_len); else passed++;
               total++; if (ar_burst !== BASIC_AR_BURST) $display("FAIL basic ar_burst got %b exp %b", ar_burst, BASIC_AR_BURST); else passed++;
               total++; if (req_ready !== 1'b0) $display("FAIL basic c1 req_ready got %b exp 0", req_ready); else passed++;
            end
            2, 3, 4, 5: begin
               total++; if ({r_ready, done} !== 2'b10) $display("FAIL basic c%0d r_ready_done got %b exp 10", c, {r_ready, done}); else passed++;
               r_data = 32'h11 * (c - 1); r_last = (c == 5);
            end
            6: begin
               r_valid = 1'b0; r_last = 1'b0;
               total++; if (done !== 1'b1) $display("FAIL basic done got %b exp 1", done); else passed++;
               total++; if (ram_addr !== 7'h12) $display("FAIL basic ram_addr got %h exp 12", ram_addr); else passed++;
               total++; if (ram_strobe !== 16'hFFFF) $display("FAIL basic ram_strobe got %h exp ffff", ram_strobe); else passed++;
               total++; if (ram_wdata !== BASIC_LINE) $display("FAIL basic ram_wdata got %h exp %h", ram_wdata, BASIC_LINE); else passed++;
               total++; if ({req_ready, err} !== 2'b00) $display("FAIL basic c6 req_ready_err got %b exp 00", {req_ready, err}); else passed++;
            end
            default: begin
               total++; if ({req_ready, done, ram_strobe} !== {2'b10, 16'h0}) $display("FAIL basic c7 req_ready_done_strobe got %b_%b_%h exp 1_0_0000", req_ready, done, ram_strobe); else passed++;
            end
         endcase
      end
   endtask

   task automatic test_stall;
      int addr_wait = 0;
      int bi = 0;
      int unstable = 0;
      int snap = done_cnt;
      logic phase = 1'b0;
      logic got = 1'b0;
      req_valid = 1'b1; req_paddr = 32'h0000_0A50; ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0;
      for (int t = 0; t < 80 && !got; t++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (done) begin
            got = 1'b1; r_valid = 1'b0; r_last = 1'b0;
            total++; if (ram_wdata !== 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000) $display("FAIL stall ram_wdata got %h exp cafe0003_cafe0002_cafe0001_cafe0000", ram_wdata); else passed++;
            total++; if (ram_addr !== 7'h25) $display("FAIL stall ram_addr got %h exp 25", ram_addr); else passed++;
            total++; if (err !== 1'b0) $display("FAIL stall err got %b exp 0", err); else passed++;
         end else if (ar_valid) begin
            if (ar_addr !== 32'h0000_0A50) unstable++;
            ar_ready = (addr_wait >= 5); addr_wait++;
         end else if (r_ready) begin
            ar_ready = 1'b0; phase = !phase;
            if (phase && bi < 4) begin
               r_valid = 1'b1; r_data = 32'hCAFE_0000 + 32'(bi); r_last = (bi == 3); bi++;
            end else begin
               r_valid = 1'b0; r_last = 1'b0;
            end
         end
      end
      total++; if (got !== 1'b1) $display("FAIL stall timeout done got %b exp 1", got); else passed++;
      total++; if (unstable != 0) $display("FAIL stall ar_addr_unstable got %0d exp 0", unstable); else passed++;
      total++; if (addr_wait != 6) $display("FAIL stall addr_cycles got %0d exp 6", addr_wait); else passed++;
      @(negedge clk); @(negedge clk); @(negedge clk);
      total++; if (done_cnt - snap != 1) $display("FAIL stall done_pulses got %0d exp 1", done_cnt - snap); else passed++;
   endtask

   task automatic test_short_burst;
      int cyc; logic [127:0] wd; logic [6:0] ra; logic er;
      run_line(32'h0000_0030, 128'h0_00000333_00000222_00000111, 3, 3, cyc, wd, ra, er);
      total++; if (cyc != 5) $display("FAIL short done_cycle got %0d exp 5", cyc); else passed++;
      total++; if (wd !== 128'hCAFE0003_00000333_00000222_00000111) $display("FAIL short ram_wdata got %h exp cafe0003_00000333_00000222_00000111", wd); else passed++;
      total++; if ({ra, er} !== {7'h03, 1'b1}) $display("FAIL short addr_err got %h_%b exp 03_1", ra, er); else passed++;
      @(negedge clk);
      total++; if ({req_ready, err} !== 2'b11) $display("FAIL short sticky_err got %b exp 11", {req_ready, err}); else passed++;
   endtask

   task automatic test_back_to_back;
      int ready_bad = 0;
      int bi = 0;
      int snap = done_cnt;
      logic got = 1'b0;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clk);
         if (c >= 1 && c <= 6 && req_ready !== 1'b0) ready_bad++;
         case (c)
            0: begin req_valid = 1'b1; req_paddr = 32'h0000_0100; ar_ready = 1'b1; r_valid = 1'b0; end
            1: begin
               total++; if (err !== 1'b0) $display("FAIL b2b err_clear got %b exp 0", err); else passed++;
            end
            2, 3, 4, 5: begin r_valid = 1'b1; r_data = 32'h50 + 32'(c - 1); r_last = (c == 5); end
            6: begin
               r_valid = 1'b0; r_last = 1'b0; req_paddr = 32'h0000_0200;
               total++; if (ram_wdata !== 128'h00000054_00000053_00000052_00000051) $display("FAIL b2b first_line got %h exp 54_53_52_51", ram_wdata); else passed++;
            end
            7: begin
               total++; if (req_ready !== 1'b1) $display("FAIL b2b c7 req_ready got %b exp 1", req_ready); else passed++;
            end
            default: begin
               req_valid = 1'b0;
               total++; if ({ar_valid, ar_addr} !== {1'b1, 32'h0000_0200}) $display("FAIL b2b second_ar got %b_%h exp 1_00000200", ar_valid, ar_addr); else passed++;
            end
         endcase
      end
      total++; if (ready_bad != 0) $display("FAIL b2b req_ready_busy got %0d exp 0", ready_bad); else passed++;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1; r_valid = 1'b0; r_last = 1'b0;
            total++; if ({ram_addr, ram_wdata} !== {7'h20, 128'h00000064_00000063_00000062_00000061}) $display("FAIL b2b second_line got %h_%h exp 20_64_63_62_61", ram_addr, ram_wdata); else passed++;
         end else if (r_ready && bi < 4) begin
            r_valid = 1'b1; r_data = 32'h61 + 32'(bi); r_last = (bi == 3); bi++;
         end else begin
            r_valid = 1'b0;
         end
      end
      @(negedge clk); @(negedge clk);
      total++; if (done_cnt - snap != 2) $display("FAIL b2b done_pulses got %0d exp 2", done_cnt - snap); else passed++;
   endtask

   task automatic test_no_last;
      int cyc; logic [127:0] wd; logic [6:0] ra; logic er;
      run_line(32'h0000_0040, 128'h00000074_00000073_00000072_00000071, 4, 0, cyc, wd, ra, er);
      total++; if (cyc != 6) $display("FAIL no_last done_cycle got %0d exp 6", cyc); else passed++;
      total++; if (wd !== 128'h00000074_00000073_00000072_00000071) $display("FAIL no_last ram_wdata got %h exp 74_73_72_71", wd); else passed++;
      total++; if ({ra, er} !== {7'h04, 1'b1}) $display("FAIL no_last addr_err got %h_%b exp 04_1", ra, er); else passed++;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) $display("FAIL no_last idle req_ready got %b exp 1", req_ready); else passed++;
   endtask

   task automatic test_reset_mid_data;
      int snap = strobe_cnt;
      req_valid = 1'b1; req_paddr = 32'h0000_0040; ar_ready = 1'b1; r_valid = 1'b0; r_last = 1'b0;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk); r_valid = 1'b1; r_data = 32'hAA;
      @(negedge clk); r_data = 32'hBB;
      @(negedge clk);
      total++; if (r_ready !== 1'b1) $display("FAIL rst_mid in_data got %b exp 1", r_ready); else passed++;
      r_valid = 1'b0; reset = 1'b1;
      #1;
      total++; if ({r_ready, ram_strobe} !== 17'h0) $display("FAIL rst_mid async got %b_%h exp 0_0000", r_ready, ram_strobe); else passed++;
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      total++; if ({req_ready, err} !== 2'b10) $display("FAIL rst_mid ready_err got %b exp 10", {req_ready, err}); else passed++;
      @(negedge clk); @(negedge clk);
      total++; if (strobe_cnt != snap) $display("FAIL rst_mid strobe_pulses got %0d exp %0d", strobe_cnt, snap); else passed++;
   endtask

`ifdef ICACHE_REFILL_CWF_EN
   task automatic test_cwf;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) @(negedge clk);
         case (c)
            0: begin req_valid = 1'b1; req_paddr = 32'h0000_0008; ar_ready = 1'b1; r_valid = 1'b0; end
            1: begin
               req_valid = 1'b0;
               total++; if ({ar_addr, ar_burst} !== {32'h0000_0008, 2'b10}) $display("FAIL cwf ar got %h_%b exp 00000008_10", ar_addr, ar_burst); else passed++;
            end
            2, 3, 4, 5: begin
               r_valid = 1'b1; r_data = 32'h9 + 32'(c - 1); r_last = (c == 5);
               #1;
               if (c == 2) begin
                  total++; if ({crit_valid, crit_data} !== {1'b1, 32'hA}) $display("FAIL cwf crit got %b_%h exp 1_0000000a", crit_valid, crit_data); else passed++;
               end else if (c == 3) begin
                  total++; if (crit_valid !== 1'b0) $display("FAIL cwf crit_late got %b exp 0", crit_valid); else passed++;
               end
            end
            default: begin
               r_valid = 1'b0; r_last = 1'b0;
               total++; if ({done, ram_wdata} !== {1'b1, 128'h0000000B_0000000A_0000000D_0000000C}) $display("FAIL cwf line got %b_%h exp 1_b_a_d_c", done, ram_wdata); else passed++;
            end
         endcase
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset;
      test_basic_latency;
      test_stall;
      test_short_burst;
      test_back_to_back;
      test_no_last;
      test_reset_mid_data;
`ifdef ICACHE_REFILL_CWF_EN
      test_cwf;
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
